lru_way_bank: RTL and testbench

LRU_WAY_BANK -- requirements
Module: lru_way_bank

---
 rtl/lru_way_bank_if.sv | 49 ++++
 rtl/lru_way_bank.sv | 227 ++++++++++++++++++++++
 tb/tb_lru_way_bank.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lru_way_bank_if.sv
// Request/response bundle between a cache controller and one LRU way bank.
// The controller drives requests through the master modport; the bank answers through slave.
interface lru_way_bank_if #(
  parameter int COUNTER_WIDTH = 8,
  parameter int NUM_SETS      = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  localparam int INDEX_WIDTH  = $clog2(NUM_SETS);
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int BE_WIDTH     = DATA_WIDTH / 8;
  localparam int TAG_WIDTH    = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  logic                     req_valid;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     req_write;
  logic                     req_alloc;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic [BE_WIDTH-1:0]      req_be;
  logic                     age_upd_valid;
  logic [COUNTER_WIDTH-1:0] age_upd_age;
  logic                     flush;

  logic                     lookup_hit;
  logic [COUNTER_WIDTH-1:0] lookup_age;
  logic                     rd_valid;
  logic                     rd_hit;
  logic                     rd_dirty;
  logic                     rd_expired;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic [TAG_WIDTH-1:0]     rd_tag;
  logic [COUNTER_WIDTH-1:0] rd_age;
  logic                     busy;

  modport master (
    output req_valid, req_addr, req_write, req_alloc, req_wdata, req_be,
    output age_upd_valid, age_upd_age, flush,
    input  lookup_hit, lookup_age, rd_valid, rd_hit, rd_dirty, rd_expired,
    input  rd_data, rd_tag, rd_age, busy
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_alloc, req_wdata, req_be,
    input  age_upd_valid, age_upd_age, flush,
    output lookup_hit, lookup_age, rd_valid, rd_hit, rd_dirty, rd_expired,
    output rd_data, rd_tag, rd_age, busy
  );
endinterface

// File: rtl/lru_way_bank.sv
// One way of a set-associative cache: tag/data/valid/dirty storage with a per-line
// age counter for LRU replacement, a one-cycle registered response and a set-serial flush.
module lru_way_bank #(
  parameter int COUNTER_WIDTH = 8,
  parameter int NUM_WAYS      = 4,
  parameter int NUM_SETS      = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  lru_way_bank_if.slave bus
);
  localparam int INDEX_WIDTH  = $clog2(NUM_SETS);
  localparam int BE_WIDTH     = DATA_WIDTH / 8;
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int WORDS        = BLOCK_SIZE * 8 / DATA_WIDTH;
  localparam int BYTE_WIDTH   = $clog2(BE_WIDTH);
  localparam int WORD_WIDTH   = OFFSET_WIDTH - BYTE_WIDTH;
  localparam int TAG_WIDTH    = ADDRESS_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  localparam logic [COUNTER_WIDTH-1:0] MAX_AGE  = COUNTER_WIDTH'(NUM_WAYS - 1);
  localparam logic [COUNTER_WIDTH-1:0] AGE_SAT  = {COUNTER_WIDTH{1'b1}};
  localparam logic [INDEX_WIDTH-1:0]   LAST_SET = INDEX_WIDTH'(NUM_SETS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [INDEX_WIDTH-1:0]   flush_cnt_r;
  logic [INDEX_WIDTH-1:0]   flush_cnt_next_s;
  logic                     flush_clr_s;

  logic [NUM_SETS-1:0]      valid_r;
  logic [NUM_SETS-1:0]      dirty_r;
  logic [COUNTER_WIDTH-1:0] age_r  [NUM_SETS];
  logic [TAG_WIDTH-1:0]     tag_r  [NUM_SETS];
  logic [DATA_WIDTH-1:0]    data_r [NUM_SETS][WORDS];

  logic [TAG_WIDTH-1:0]     req_tag_s;
  logic [INDEX_WIDTH-1:0]   req_set_s;
  logic [WORD_WIDTH-1:0]    req_word_s;

  logic                     line_valid_s;
  logic                     line_dirty_s;
  logic [TAG_WIDTH-1:0]     line_tag_s;
  logic [COUNTER_WIDTH-1:0] line_age_s;
  logic [DATA_WIDTH-1:0]    line_word_s;

  logic                     accept_s;
  logic                     hit_s;
  logic                     expired_s;
  logic [COUNTER_WIDTH-1:0] age_next_s;
  logic [DATA_WIDTH-1:0]    merged_s;
  logic [DATA_WIDTH-1:0]    wr_word_s;
  logic                     data_we_s;
  logic                     tag_we_s;

  logic                     rd_valid_r;
  logic                     rd_hit_r;
  logic                     rd_dirty_r;
  logic                     rd_expired_r;
  logic [DATA_WIDTH-1:0]    rd_data_r;
  logic [TAG_WIDTH-1:0]     rd_tag_r;
  logic [COUNTER_WIDTH-1:0] rd_age_r;

  assign req_tag_s  = bus.req_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign req_set_s  = bus.req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word_s = bus.req_addr[OFFSET_WIDTH-1:BYTE_WIDTH];

  assign line_valid_s = valid_r[req_set_s];
  assign line_dirty_s = dirty_r[req_set_s];
  assign line_tag_s   = tag_r[req_set_s];
  assign line_age_s   = age_r[req_set_s];
  assign line_word_s  = data_r[req_set_s][req_word_s];

  // Requests arriving while a flush walks the sets are dropped entirely.
  assign accept_s  = bus.req_valid && (state_r == ST_IDLE);
  assign hit_s     = line_valid_s && (line_tag_s == req_tag_s);
  assign expired_s = !line_valid_s || (line_age_s >= MAX_AGE);
  assign data_we_s = accept_s && (bus.req_alloc || (bus.req_write && hit_s));
  assign tag_we_s  = accept_s && bus.req_alloc;
  assign wr_word_s = bus.req_alloc ? bus.req_wdata : merged_s;

  // Age the line only while it is younger than the accessed way; a touch resets it.
  always_comb begin
    age_next_s = line_age_s;
    if (hit_s || bus.req_alloc) begin
      age_next_s = '0;
    end else if (line_valid_s && (line_age_s < bus.age_upd_age) && (line_age_s != AGE_SAT)) begin
      age_next_s = line_age_s + COUNTER_WIDTH'(1);
    end else begin
      age_next_s = line_age_s;
    end
  end

  // Byte-lane merge of write data into the currently stored word.
  always_comb begin
    merged_s = line_word_s;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (bus.req_be[b]) begin
        merged_s[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
      end else begin
        merged_s[b*8 +: 8] = line_word_s[b*8 +: 8];
      end
    end
  end

  // Flush sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= '0;
    end else begin
      state_r     <= state_next_s;
      flush_cnt_r <= flush_cnt_next_s;
    end
  end

  // Flush sequencer next state: one set cleared per cycle, lowest index first.
  always_comb begin
    state_next_s     = state_r;
    flush_cnt_next_s = flush_cnt_r;
    flush_clr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.flush) begin
          state_next_s     = ST_FLUSH;
          flush_cnt_next_s = '0;
        end else begin
          state_next_s     = ST_IDLE;
          flush_cnt_next_s = flush_cnt_r;
        end
      end
      ST_FLUSH: begin
        flush_clr_s = 1'b1;
        if (flush_cnt_r == LAST_SET) begin
          state_next_s     = ST_IDLE;
          flush_cnt_next_s = '0;
        end else begin
          state_next_s     = ST_FLUSH;
          flush_cnt_next_s = flush_cnt_r + INDEX_WIDTH'(1);
        end
      end
      default: begin
        state_next_s     = ST_IDLE;
        flush_cnt_next_s = '0;
      end
    endcase
  end

  // Line status bits and ages; these are the only per-line fields under reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
      for (int i = 0; i < NUM_SETS; i++) begin
        age_r[i] <= '0;
      end
    end else begin
      if (flush_clr_s) begin
        valid_r[flush_cnt_r] <= 1'b0;
        dirty_r[flush_cnt_r] <= 1'b0;
      end
      if (accept_s) begin
        if (bus.req_alloc) begin
          valid_r[req_set_s] <= 1'b1;
          dirty_r[req_set_s] <= 1'b0;
        end else if (bus.req_write && hit_s) begin
          dirty_r[req_set_s] <= 1'b1;
        end
        if (bus.age_upd_valid) begin
          age_r[req_set_s] <= age_next_s;
        end
      end
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (data_we_s) begin
      data_r[req_set_s][req_word_s] <= wr_word_s;
    end
    if (tag_we_s) begin
      tag_r[req_set_s] <= req_tag_s;
    end
  end

  // Registered response: reports the line as it stood before this request's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r   <= 1'b0;
      rd_hit_r     <= 1'b0;
      rd_dirty_r   <= 1'b0;
      rd_expired_r <= 1'b0;
      rd_data_r    <= '0;
      rd_tag_r     <= '0;
      rd_age_r     <= '0;
    end else begin
      rd_valid_r <= accept_s;
      if (accept_s) begin
        rd_hit_r     <= hit_s && !bus.req_alloc;
        rd_dirty_r   <= line_dirty_s;
        rd_expired_r <= expired_s;
        rd_data_r    <= line_word_s;
        rd_tag_r     <= line_tag_s;
        rd_age_r     <= line_age_s;
      end
    end
  end

  assign bus.lookup_hit = hit_s;
  assign bus.lookup_age = line_age_s;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.rd_hit     = rd_hit_r;
  assign bus.rd_dirty   = rd_dirty_r;
  assign bus.rd_expired = rd_expired_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.rd_tag     = rd_tag_r;
  assign bus.rd_age     = rd_age_r;
  assign bus.busy       = (state_r == ST_FLUSH);

endmodule

// File: tb/tb_lru_way_bank.sv
// Directed bench for lru_way_bank with default parameters (16 sets, 32-byte lines).
// Set 4 holds A1/A2 (tags 0x091A00 / 0x2B3C00); set 2 holds address 0x40.
module tb_lru_way_bank;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   busy_cycles;
  logic stray;

  localparam logic [31:0] A1 = 32'h1234_0080;
  localparam logic [31:0] A2 = 32'h5678_0080;
  localparam logic [31:0] A0 = 32'h0000_0040;
  localparam logic [22:0] T1 = 23'h091A00;
  localparam logic [22:0] T2 = 23'h2B3C00;

  always #5 clk = ~clk;

  lru_way_bank_if bus ();
  lru_way_bank dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.req_addr      = 32'h0;
    bus.req_write     = 1'b0;
    bus.req_alloc     = 1'b0;
    bus.req_wdata     = 32'h0;
    bus.req_be        = 4'h0;
    bus.age_upd_valid = 1'b0;
    bus.age_upd_age   = 8'h0;
    bus.flush         = 1'b0;
  endtask

  // One request cycle; returns at the following falling edge with the response registered.
  task automatic do_req(input logic [31:0] addr, input logic wr, input logic al,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic uv, input logic [7:0] ua);
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_addr      = addr;
    bus.req_write     = wr;
    bus.req_alloc     = al;
    bus.req_wdata     = wd;
    bus.req_be        = be;
    bus.age_upd_valid = uv;
    bus.age_upd_age   = ua;
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #12;
    total++; assert (bus.busy === 1'b0) else begin bad++; $error("FAIL rst_busy observed=%0h expected=%0h", bus.busy, 1'b0); end
    total++; assert (bus.rd_valid === 1'b0) else begin bad++; $error("FAIL rst_rd_valid observed=%0h expected=%0h", bus.rd_valid, 1'b0); end
    total++; assert (bus.rd_data === 32'h0) else begin bad++; $error("FAIL rst_rd_data observed=%0h expected=%0h", bus.rd_data, 32'h0); end
    total++; assert (bus.rd_tag === 23'h0) else begin bad++; $error("FAIL rst_rd_tag observed=%0h expected=%0h", bus.rd_tag, 23'h0); end
    total++; assert (bus.rd_age === 8'h0) else begin bad++; $error("FAIL rst_rd_age observed=%0h expected=%0h", bus.rd_age, 8'h0); end
    @(negedge clk);
    rst = 1'b0;

    // Read of an empty line after reset
    do_req(A0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'h0);
    total++; assert (bus.rd_valid === 1'b1) else begin bad++; $error("FAIL empty_rd_valid observed=%0h expected=%0h", bus.rd_valid, 1'b1); end
    total++; assert (bus.rd_hit === 1'b0) else begin bad++; $error("FAIL empty_hit observed=%0h expected=%0h", bus.rd_hit, 1'b0); end
    total++; assert (bus.rd_expired === 1'b1) else begin bad++; $error("FAIL empty_expired observed=%0h expected=%0h", bus.rd_expired, 1'b1); end
    total++; assert (bus.rd_dirty === 1'b0) else begin bad++; $error("FAIL empty_dirty observed=%0h expected=%0h", bus.rd_dirty, 1'b0); end
    @(negedge clk);
    total++; assert (bus.rd_valid === 1'b0) else begin bad++; $error("FAIL idle_rd_valid observed=%0h expected=%0h", bus.rd_valid, 1'b0); end

    // Fill A1, then read it back
    do_req(A1, 1'b0, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0, 8'h0);
    total++; assert (bus.rd_hit === 1'b0) else begin bad++; $error("FAIL fill_hit observed=%0h expected=%0h", bus.rd_hit, 1'b0); end
    do_req(A1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'h0);
    total++; assert (bus.rd_hit === 1'b1) else begin bad++; $error("FAIL rd1_hit observed=%0h expected=%0h", bus.rd_hit, 1'b1); end
    total++; assert (bus.rd_data === 32'hDEADBEEF) else begin bad++; $error("FAIL rd1_data observed=%0h expected=%0h", bus.rd_data, 32'hDEADBEEF); end
    total++; assert (bus.rd_dirty === 1'b0) else begin bad++; $error("FAIL rd1_dirty observed=%0h expected=%0h", bus.rd_dirty, 1'b0); end
    total++; assert (bus.rd_tag === T1) else begin bad++; $error("FAIL rd1_tag observed=%0h expected=%0h", bus.rd_tag, T1); end

    // Partial write hit returns the old word
    do_req(A1, 1'b1, 1'b0, 32'h0000AAAA, 4'b0011, 1'b0, 8'h0);
    total++; assert (bus.rd_data === 32'hDEADBEEF) else begin bad++; $error("FAIL wr_old_data observed=%0h expected=%0h", bus.rd_data, 32'hDEADBEEF); end
    do_req(A1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'h0);
    total++; assert (bus.rd_data === 32'hDEADAAAA) else begin bad++; $error("FAIL wr_new_data observed=%0h expected=%0h", bus.rd_data, 32'hDEADAAAA); end
    total++; assert (bus.rd_dirty === 1'b1) else begin bad++; $error("FAIL wr_dirty observed=%0h expected=%0h", bus.rd_dirty, 1'b1); end

    // Conflicting tag: victim information, plus ageing with upd age 3
    do_req(A2, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 8'd3);
    total++; assert (bus.rd_hit === 1'b0) else begin bad++; $error("FAIL vic_hit observed=%0h expected=%0h", bus.rd_hit, 1'b0); end
    total++; assert (bus.rd_tag === T1) else begin bad++; $error("FAIL vic_tag observed=%0h expected=%0h", bus.rd_tag, T1); end
    total++; assert (bus.rd_dirty === 1'b1) else begin bad++; $error("FAIL vic_dirty observed=%0h expected=%0h", bus.rd_dirty, 1'b1); end
    total++; assert (bus.rd_age === 8'd0) else begin bad++; $error("FAIL age0 observed=%0h expected=%0h", bus.rd_age, 8'd0); end
    do_req(A2, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 8'd3);
    total++; assert (bus.rd_age === 8'd1) else begin bad++; $error("FAIL age1 observed=%0h expected=%0h", bus.rd_age, 8'd1); end
    do_req(A2, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 8'd3);
    total++; assert (bus.rd_age === 8'd2) else begin bad++; $error("FAIL age2 observed=%0h expected=%0h", bus.rd_age, 8'd2); end
    total++; assert (bus.rd_expired === 1'b0) else begin bad++; $error("FAIL age2_expired observed=%0h expected=%0h", bus.rd_expired, 1'b0); end
    do_req(A2, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 8'd3);
    total++; assert (bus.rd_age === 8'd3) else begin bad++; $error("FAIL age3 observed=%0h expected=%0h", bus.rd_age, 8'd3); end
    total++; assert (bus.rd_expired === 1'b1) else begin bad++; $error("FAIL age3_expired observed=%0h expected=%0h", bus.rd_expired, 1'b1); end
    do_req(A2, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'd7);
    total++; assert (bus.rd_age === 8'd3) else begin bad++; $error("FAIL age_sat observed=%0h expected=%0h", bus.rd_age, 8'd3); end

    // Combinational lookup with no strobe: age must not have moved without age_upd_valid
    @(negedge clk);
    bus.req_addr = A1;
    #1;
    total++; assert (bus.lookup_hit === 1'b1) else begin bad++; $error("FAIL lk_hit observed=%0h expected=%0h", bus.lookup_hit, 1'b1); end
    total++; assert (bus.lookup_age === 8'd3) else begin bad++; $error("FAIL lk_age observed=%0h expected=%0h", bus.lookup_age, 8'd3); end
    idle_inputs();

    // Hit with age update clears age
    do_req(A1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 8'd3);
    total++; assert (bus.rd_hit === 1'b1) else begin bad++; $error("FAIL touch_hit observed=%0h expected=%0h", bus.rd_hit, 1'b1); end
    do_req(A1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'd0);
    total++; assert (bus.rd_age === 8'd0) else begin bad++; $error("FAIL touch_age observed=%0h expected=%0h", bus.rd_age, 8'd0); end

    // Alloc on a hit overrides write and clears dirty
    do_req(A1, 1'b1, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 8'd0);
    total++; assert (bus.rd_hit === 1'b0) else begin bad++; $error("FAIL realloc_hit observed=%0h expected=%0h", bus.rd_hit, 1'b0); end
    total++; assert (bus.rd_data === 32'hDEADAAAA) else begin bad++; $error("FAIL realloc_old observed=%0h expected=%0h", bus.rd_data, 32'hDEADAAAA); end
    do_req(A1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'd0);
    total++; assert (bus.rd_data === 32'hCAFEF00D) else begin bad++; $error("FAIL realloc_data observed=%0h expected=%0h", bus.rd_data, 32'hCAFEF00D); end
    total++; assert (bus.rd_dirty === 1'b0) else begin bad++; $error("FAIL realloc_dirty observed=%0h expected=%0h", bus.rd_dirty, 1'b0); end

    // Replace with A2; a later write miss to A1 must not disturb it
    do_req(A2, 1'b0, 1'b1, 32'h11112222, 4'h0, 1'b0, 8'd0);
    total++; assert (bus.rd_tag === T1) else begin bad++; $error("FAIL repl_tag observed=%0h expected=%0h", bus.rd_tag, T1); end
    do_req(A1, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 8'd0);
    total++; assert (bus.rd_hit === 1'b0) else begin bad++; $error("FAIL wmiss_hit observed=%0h expected=%0h", bus.rd_hit, 1'b0); end
    do_req(A2, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'd0);
    total++; assert (bus.rd_data === 32'h11112222) else begin bad++; $error("FAIL wmiss_data observed=%0h expected=%0h", bus.rd_data, 32'h11112222); end
    total++; assert (bus.rd_dirty === 1'b0) else begin bad++; $error("FAIL wmiss_dirty observed=%0h expected=%0h", bus.rd_dirty, 1'b0); end

    // Flush together with a read hit; requests and flush held high throughout
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = A2;
    @(negedge clk);
    total++; assert (bus.rd_valid === 1'b1) else begin bad++; $error("FAIL fl_rd_valid observed=%0h expected=%0h", bus.rd_valid, 1'b1); end
    total++; assert (bus.rd_hit === 1'b1) else begin bad++; $error("FAIL fl_rd_hit observed=%0h expected=%0h", bus.rd_hit, 1'b1); end
    total++; assert (bus.busy === 1'b1) else begin bad++; $error("FAIL fl_busy_rise observed=%0h expected=%0h", bus.busy, 1'b1); end
    busy_cycles = 1;
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      stray = stray | bus.rd_valid;
      if (bus.busy) begin
        busy_cycles++;
      end else begin
        break;
      end
    end
    idle_inputs();
    total++; assert (busy_cycles === 16) else begin bad++; $error("FAIL fl_cycles observed=%0d expected=%0d", busy_cycles, 16); end
    total++; assert (stray === 1'b0) else begin bad++; $error("FAIL fl_ignored observed=%0h expected=%0h", stray, 1'b0); end

    do_req(A2, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'd0);
    total++; assert (bus.rd_hit === 1'b0) else begin bad++; $error("FAIL post_fl_hit observed=%0h expected=%0h", bus.rd_hit, 1'b0); end
    total++; assert (bus.rd_expired === 1'b1) else begin bad++; $error("FAIL post_fl_expired observed=%0h expected=%0h", bus.rd_expired, 1'b1); end
    total++; assert (bus.rd_tag === T2) else begin bad++; $error("FAIL post_fl_tag observed=%0h expected=%0h", bus.rd_tag, T2); end
    total++; assert (bus.rd_data === 32'h11112222) else begin bad++; $error("FAIL post_fl_data observed=%0h expected=%0h", bus.rd_data, 32'h11112222); end
    total++; assert (bus.busy === 1'b0) else begin bad++; $error("FAIL post_fl_busy observed=%0h expected=%0h", bus.busy, 1'b0); end

    // Reset in the fifth flush cycle aborts immediately
    do_req(A0, 1'b0, 1'b1, 32'h00000055, 4'h0, 1'b0, 8'd0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (4) @(negedge clk);
    total++; assert (bus.busy === 1'b1) else begin bad++; $error("FAIL mid_busy observed=%0h expected=%0h", bus.busy, 1'b1); end
    #2;
    rst = 1'b1;
    #1;
    total++; assert (bus.busy === 1'b0) else begin bad++; $error("FAIL rst_abort_busy observed=%0h expected=%0h", bus.busy, 1'b0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; assert (bus.busy === 1'b0) else begin bad++; $error("FAIL rst_idle_busy observed=%0h expected=%0h", bus.busy, 1'b0); end
    do_req(A0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 8'd0);
    total++; assert (bus.rd_valid === 1'b1) else begin bad++; $error("FAIL after_rst_valid observed=%0h expected=%0h", bus.rd_valid, 1'b1); end
    total++; assert (bus.rd_hit === 1'b0) else begin bad++; $error("FAIL after_rst_hit observed=%0h expected=%0h", bus.rd_hit, 1'b0); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
